// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII Ethernet TX framer and its CRC engine.
// Also used by the framer's optional sequence-number build (`ETH_FRAME_SEQ_EN).
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        HDR,
        PAY,
        FCS,
        IFG
    } state_t;

    localparam int PRE_DIBITS = 28;
    localparam int SFD_DIBITS = 4;
    localparam int FCS_DIBITS = 16;

    localparam logic [1:0] PRE_DIBIT      = 2'b01;
    localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Reflected CRC-32 register advanced two bits per clock, d[0] first (wire order).
module crc32_dibit
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [1:0]  d,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    // NOTE: blocking assignments are correct here; each loop pass must see the previous pass's result.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 2; i++) begin
            crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ d[i]) ? CRC_POLY : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/eth_rmii_tx_framer.sv
// Wraps the upstream dibit stream in an Ethernet II frame on the RMII TX pins.
// Define ETH_FRAME_SEQ_EN to append a 16-bit frame sequence number to the header.
module eth_rmii_tx_framer
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC        = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC        = 48'h6900_0000_0111,
    parameter logic [15:0] ETHERTYPE      = 16'h88B5,
    parameter int          PAYLOAD_DIBITS = 1292,
    parameter int          LEAD           = 2,
    parameter int          IFG_DIBITS     = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_en,
    input  logic       in_axiov,
    input  logic [1:0] in_axiod,
    output logic       in_stall,
    output logic       tx_en,
    output logic [1:0] txd,
    output logic       frame_done,
    output logic       underrun
);

`ifdef ETH_FRAME_SEQ_EN
    localparam int HDR_DIBITS = 64;
`else
    localparam int HDR_DIBITS = 56;
`endif
    localparam int HDR_BITS  = 2 * HDR_DIBITS;
    localparam int HDR_BYTES = HDR_DIBITS / 4;
    localparam int HDR_IDX_W = $clog2(HDR_BITS);
    localparam int CNT_W     = $clog2(max_int(max_int(PAYLOAD_DIBITS, IFG_DIBITS), HDR_DIBITS) + 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     state_len;
    logic                 state_last;
    logic [HDR_BITS-1:0]  hdr_msb;
    logic [HDR_BITS-1:0]  hdr_lsb;
    logic [HDR_IDX_W-1:0] hdr_idx;
    logic [31:0]          crc;
    logic [31:0]          fcs_word;
    logic [1:0]           dibit;
    logic                 crc_clear;
    logic                 crc_en;
    logic                 stall_next;
    logic                 under_flag;

`ifdef ETH_FRAME_SEQ_EN
    logic [15:0] seq;
    assign hdr_msb = {DST_MAC, SRC_MAC, ETHERTYPE, seq};
`else
    assign hdr_msb = {DST_MAC, SRC_MAC, ETHERTYPE};
`endif

    // Bytes leave most-significant first but each byte goes LSB dibit first, so
    // reverse the byte order once and header dibit n becomes hdr_lsb[2n+1:2n].
    always_comb begin
        hdr_lsb = '0;
        for (int b = 0; b < HDR_BYTES; b++) begin
            hdr_lsb[8*b +: 8] = hdr_msb[8*(HDR_BYTES-1-b) +: 8];
        end
    end

    assign hdr_idx    = {cnt[HDR_IDX_W-2:0], 1'b0};
    assign fcs_word   = under_flag ? crc : ~crc;
    assign state_last = (cnt == state_len);
    assign crc_clear  = (state == IDLE) || (state == PRE) || (state == SFD);
    assign crc_en     = (state == HDR) || (state == PAY);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_len = '0;
        dibit     = 2'b00;
        case (state)
            PRE: begin
                state_len = CNT_W'(PRE_DIBITS - 1);
                dibit     = PRE_DIBIT;
            end
            SFD: begin
                state_len = CNT_W'(SFD_DIBITS - 1);
                dibit     = state_last ? SFD_LAST_DIBIT : PRE_DIBIT;
            end
            HDR: begin
                state_len = CNT_W'(HDR_DIBITS - 1);
                dibit     = hdr_lsb[hdr_idx +: 2];
            end
            PAY: begin
                state_len = CNT_W'(PAYLOAD_DIBITS - 1);
                dibit     = in_axiov ? in_axiod : 2'b00;
            end
            FCS: begin
                state_len = CNT_W'(FCS_DIBITS - 1);
                dibit     = fcs_word[{cnt[3:0], 1'b0} +: 2];
            end
            IFG: begin
                state_len = CNT_W'(IFG_DIBITS - 1);
            end
            default: ;
        endcase
    end

    // Upstream is released LEAD+1 cycles ahead in state time: one cycle for the
    // in_stall register, LEAD for its own pipeline, so dibit 0 meets PAY cycle 0.
    always_comb begin
        stall_next = 1'b1;
        if ((state == HDR) && (cnt >= CNT_W'(HDR_DIBITS - LEAD - 1))) begin
            stall_next = 1'b0;
        end
        if ((state == PAY) && (cnt < CNT_W'(PAYLOAD_DIBITS - LEAD - 1))) begin
            stall_next = 1'b0;
        end
    end

    crc32_dibit u_crc (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(crc_clear),
        .en   (crc_en),
        .d    (dibit),
        .crc  (crc)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            tx_en      <= 1'b0;
            txd        <= 2'b00;
            in_stall   <= 1'b1;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            under_flag <= 1'b0;
`ifdef ETH_FRAME_SEQ_EN
            seq        <= 16'h0000;
`endif
        end else begin
            txd        <= dibit;
            tx_en      <= (state inside {PRE, SFD, HDR, PAY, FCS});
            in_stall   <= stall_next;
            frame_done <= (state == IFG) && state_last;
            underrun   <= (state == IFG) && state_last && under_flag;

            if ((state == PAY) && !in_axiov) begin
                under_flag <= 1'b1;
            end

            if (state == IDLE) begin
                if (frame_en) begin
                    state <= PRE;
                end
            end else if (!state_last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    PRE: state <= SFD;
                    SFD: state <= HDR;
                    HDR: state <= PAY;
                    PAY: state <= FCS;
                    FCS: state <= IFG;
                    default: begin
                        // Going straight to PRE keeps back-to-back frames at exactly IFG_DIBITS idle dibits.
                        state      <= frame_en ? PRE : IDLE;
                        under_flag <= 1'b0;
`ifdef ETH_FRAME_SEQ_EN
                        seq        <= seq + 16'h0001;
`endif
                    end
                endcase
            end
        end
    end

endmodule
